// File: rtl/nios2_jtag_debug_sysclk_queue.sv
// System-clock side of the Nios II JTAG debug bridge: synchronises the virtual-JTAG
// update strobes, queues {ir_in, sr} per update-DR and replays commands to the OCI logic.
module nios2_jtag_debug_sysclk_queue #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [SR_W-1:0]            sr,
    input  logic                       cmd_ready,
    input  logic                       clr_overflow,
    output logic [SR_W-1:0]            jdo,
    output logic [(2**IR_W)-1:0]       take_action,
    output logic [(2**IR_W)-1:0]       take_no_action,
    output logic                       uir_pulse,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow
);

    localparam int STROBE_W = 2 ** IR_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = $clog2(DEPTH + 1);
    localparam int ENT_W    = IR_W + SR_W;
    localparam int ARM_MAX  = SYNC_STAGES + 1;
    localparam int ARM_W    = $clog2(ARM_MAX + 1);

    // Synchronisers, edge-detect history and the post-reset arm counter.
    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_prev_q, uir_prev_q;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   armed;
    logic                   udr_edge, uir_edge;

    // Command queue storage and bookkeeping.
    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;

    // Issue-side registers.
    logic [SR_W-1:0]     jdo_q, jdo_d;
    logic [STROBE_W-1:0] act_q, act_d;
    logic [STROBE_W-1:0] noact_q, noact_d;
    logic                uir_pulse_q, uir_pulse_d;

    logic                pop;
    logic                push_ok;
    logic                ovf_evt;
    logic [ENT_W-1:0]    head;
    logic [IR_W-1:0]     head_ir;
    logic [SR_W-1:0]     head_sr;

    // Edges are ignored until the synchronisers have flushed their reset values,
    // so a level already high at reset release never looks like a fresh rise.
    assign armed    = (arm_cnt_q == ARM_W'(ARM_MAX));
    assign udr_edge = armed && udr_sync_q[SYNC_STAGES-1] && !udr_prev_q;
    assign uir_edge = armed && uir_sync_q[SYNC_STAGES-1] && !uir_prev_q;

    assign head    = mem_q[rd_ptr_q];
    assign head_ir = head[ENT_W-1:SR_W];
    assign head_sr = head[SR_W-1:0];

    // Handshake: a command is consumed in any cycle where the queue is non-empty and
    // cmd_ready is high; its strobe and jdo appear in the following cycle.
    always_comb begin
        arm_cnt_d   = arm_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        jdo_d       = jdo_q;
        act_d       = '0;
        noact_d     = '0;
        uir_pulse_d = uir_edge;

        pop     = (level_q != '0) && cmd_ready;
        push_ok = udr_edge && ((level_q != LVL_W'(DEPTH)) || pop);
        ovf_evt = udr_edge && (level_q == LVL_W'(DEPTH)) && !pop;

        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            jdo_d    = head_sr;
            if (head_sr[ACT_BIT]) begin
                act_d[head_ir] = 1'b1;
            end else begin
                noact_d[head_ir] = 1'b1;
            end
        end

        level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

        // A new overflow event takes priority over a simultaneous clear.
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q  <= '0;
            uir_sync_q  <= '0;
            udr_prev_q  <= 1'b0;
            uir_prev_q  <= 1'b0;
            arm_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            jdo_q       <= '0;
            act_q       <= '0;
            noact_q     <= '0;
            uir_pulse_q <= 1'b0;
        end else begin
            udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_prev_q  <= udr_sync_q[SYNC_STAGES-1];
            uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
            arm_cnt_q   <= arm_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            jdo_q       <= jdo_d;
            act_q       <= act_d;
            noact_q     <= noact_d;
            uir_pulse_q <= uir_pulse_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {ir_in, sr};
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign uir_pulse      = uir_pulse_q;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;

endmodule
